// File: rtl/grf_writeback_arbiter.sv
// Owns the GRF write port: merges the in-order write-back with a small FIFO of
// long-latency results, and tracks registers whose long-latency result is still pending.
module grf_writeback_arbiter #(
  parameter int LQ_DEPTH = 2,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lr_valid,
  output logic              lr_ready,
  input  logic [4:0]        lr_addr,
  input  logic [DATA_W-1:0] lr_data,
  input  logic              iss_en,
  input  logic [4:0]        iss_addr,
  input  logic [4:0]        query_addr_1,
  input  logic [4:0]        query_addr_2,
  output logic              pending_1,
  output logic              pending_2,
  output logic              grf_write_enable,
  output logic [4:0]        grf_write_addr,
  output logic [DATA_W-1:0] grf_write_value
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [4:0]        q_addr [LQ_DEPTH];
  logic [DATA_W-1:0] q_data [LQ_DEPTH];
  logic [PTR_W-1:0]  head_ptr, tail_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pend, pend_next;

  logic pipe_req, empty, full, push, pop;
  logic [4:0] head_addr;

  assign pipe_req  = wb_en && (wb_addr != 5'd0);
  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(LQ_DEPTH));
  assign head_addr = q_addr[head_ptr];

  assign lr_ready = !full && !reset;
  // $0 results complete the handshake but never occupy a slot.
  assign push     = lr_valid && lr_ready && (lr_addr != 5'd0);
  assign pop      = !reset && !pipe_req && !empty;

  always_comb begin
    grf_write_enable = 1'b0;
    grf_write_addr   = 5'd0;
    grf_write_value  = '0;
    if (!reset && pipe_req) begin
      grf_write_enable = 1'b1;
      grf_write_addr   = wb_addr;
      grf_write_value  = wb_data;
    end else if (pop) begin
      grf_write_enable = 1'b1;
      grf_write_addr   = head_addr;
      grf_write_value  = q_data[head_ptr];
    end
  end

  // Set after clear so a same-cycle reissue of the draining register keeps its bit.
  always_comb begin
    pend_next = pend;
    if (pop)
      pend_next[head_addr] = 1'b0;
    if (iss_en && (iss_addr != 5'd0))
      pend_next[iss_addr] = 1'b1;
  end

  // The GRF forwards its own write port, so a register draining this cycle reads as ready.
  assign pending_1 = pend[query_addr_1] && (query_addr_1 != 5'd0) &&
                     !(pop && (head_addr == query_addr_1));
  assign pending_2 = pend[query_addr_2] && (query_addr_2 != 5'd0) &&
                     !(pop && (head_addr == query_addr_2));

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
      pend     <= '0;
    end else begin
      pend <= pend_next;
      if (push)
        tail_ptr <= tail_ptr + 1'b1;
      if (pop)
        head_ptr <= head_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail_ptr] <= lr_addr;
      q_data[tail_ptr] <= lr_data;
    end
  end

endmodule
